load_store_unit: RTL and testbench

Multicycle load/store unit for the core: the memory-facing producer of the `data` word that the writeback result mux selects on loads. Accepts one load or store request per operation from the control FSM. Drives a single-port, word-addressed memory with a request/ready handshake. Returns byte/halfword/word load data aligned and sign- or zero-extended in a holding register, and signals completion or a misalignment error.

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: one request per operation, a single-port word-addressed memory
// behind a req/ready handshake, and a registered, aligned and extended load result.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Handshake: mem_req holds with constant addr/we/wdata/wmask until the memory
  // answers with mem_ready=1 in the same cycle; that cycle is the transfer.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t     state;
  logic       st_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic        req_legal;
  logic [31:0] issue_wdata;
  logic [3:0]  issue_wmask;
  logic [31:0] load_fmt;

  assign state_dbg = state;

  always_comb begin
    req_legal = 1'b1;
    if (is_store) begin
      if (funct3 != 3'b000 && funct3 != 3'b001 && funct3 != 3'b010) req_legal = 1'b0;
    end else begin
      if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) req_legal = 1'b0;
    end
    if (funct3[1:0] == 2'b01 && addr[0]) req_legal = 1'b0;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) req_legal = 1'b0;
  end

  // Store lanes are replicated so the mask alone selects the written bytes.
  always_comb begin
    issue_wdata = 32'h0;
    issue_wmask = 4'b0000;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          issue_wdata = {4{store_data[7:0]}};
          issue_wmask = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          issue_wdata = {2{store_data[15:0]}};
          issue_wmask = 4'b0011 << addr[1:0];
        end
        default: begin
          issue_wdata = store_data;
          issue_wmask = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb       = mem_rdata[8*off_q +: 8];
    lh       = mem_rdata[16*off_q[1] +: 16];
    load_fmt = mem_rdata;
    case (f3_q)
      3'b000:  load_fmt = {{24{lb[7]}}, lb};
      3'b001:  load_fmt = {{16{lh[15]}}, lh};
      3'b100:  load_fmt = {24'h0, lb};
      3'b101:  load_fmt = {16'h0, lh};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      st_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'b0000;
      data      <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (req_legal) begin
              state     <= S_ACCESS;
              st_q      <= is_store;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= addr[ADDR_W-1:2];
              mem_wdata <= issue_wdata;
              mem_wmask <= issue_wmask;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (!st_q) data <= load_fmt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized load/store sequences against load_store_unit with a
// queue of expected load results and a reference formatter.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state_dbg;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_data;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .data(data), .busy(busy),
    .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w >> (8 * o);
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // driver: present a request across one posedge, return at the next negedge
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0; addr = $urandom(); store_data = $urandom();
  endtask

  // memory side: hold ready low for 'delay' cycles, then complete
  task automatic access(input int delay, input logic [31:0] rd, input logic [29:0] ea,
                        input logic st, input logic [31:0] ew, input logic [3:0] em);
    logic [31:0] e;
    for (int i = 0; i <= delay; i++) begin
      check("mem_req_hi", {31'h0, mem_req}, 32'd1);
      check("busy_hi", {31'h0, busy}, 32'd1);
      check("mem_addr", {2'b00, mem_addr}, {2'b00, ea});
      check("mem_we", {31'h0, mem_we}, {31'h0, st});
      check("mem_wmask", {28'h0, mem_wmask}, {28'h0, em});
      if (st) check("mem_wdata", mem_wdata, ew);
      check("done_early", {31'h0, done}, 32'd0);
      mem_ready = (i == delay);
      mem_rdata = (i == delay) ? rd : $urandom();
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom();
    check("done_pulse", {31'h0, done}, 32'd1);
    check("mem_req_lo", {31'h0, mem_req}, 32'd0);
    check("mem_we_lo", {31'h0, mem_we}, 32'd0);
    check("err_lo", {31'h0, err}, 32'd0);
    if (!st) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check("load_data", data, e);
      last_data = e;
    end else begin
      check("data_kept", data, last_data);
    end
    @(negedge clk);
    check("done_end", {31'h0, done}, 32'd0);
    check("busy_end", {31'h0, busy}, 32'd0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                         input int delay, input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    issue(1'b0, f3, a, 32'h0);
    access(delay, rd, a[31:2], 1'b0, 32'h0, 4'b0000);
  endtask

  task automatic do_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    issue(st, f3, a, 32'h1234_5678);
    check("err_pulse", {31'h0, err}, 32'd1);
    check("err_busy", {31'h0, busy}, 32'd1);
    check("err_no_req", {31'h0, mem_req}, 32'd0);
    check("err_no_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    check("err_end", {31'h0, err}, 32'd0);
    check("err_no_req2", {31'h0, mem_req}, 32'd0);
    check("err_no_done2", {31'h0, done}, 32'd0);
    check("err_data_kept", data, last_data);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] rd;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0; last_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req}, 32'd0);
    check("rst_mem_we", {31'h0, mem_we}, 32'd0);
    check("rst_wmask", {28'h0, mem_wmask}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_addr", {2'b00, mem_addr}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(3'b010, 32'h104, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    do_load(3'b000, 32'h203, 32'h80112233, 3, 32'hFFFFFF80);
    do_load(3'b100, 32'h203, 32'h80112233, 3, 32'h00000080);

    issue(1'b1, 3'b001, 32'h12, 32'h0000ABCD);
    access(0, 32'h0, 30'h4, 1'b1, 32'hABCDABCD, 4'b1100);
    issue(1'b1, 3'b000, 32'h21, 32'h000000A5);
    access(1, 32'h0, 30'h8, 1'b1, 32'hA5A5A5A5, 4'b0010);
    issue(1'b1, 3'b010, 32'h40, 32'h13579BDF);
    access(0, 32'h0, 30'h10, 1'b1, 32'h13579BDF, 4'b1111);

    do_load(3'b001, 32'h102, 32'h8001_7FFF, 0, 32'hFFFF8001);
    do_load(3'b101, 32'h100, 32'h1234_8765, 2, 32'h00008765);

    do_err(1'b0, 3'b001, 32'h101);
    do_err(1'b1, 3'b010, 32'h102);
    do_err(1'b0, 3'b011, 32'h100);
    do_err(1'b1, 3'b100, 32'h100);

    // reset while the memory is stalling
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    repeat (2) begin
      check("stall_req", {31'h0, mem_req}, 32'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_req", {31'h0, mem_req}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_data", data, 32'd0);
    check("mid_rst_done", {31'h0, done}, 32'd0);
    last_data = 32'h0;
    @(negedge clk);
    do_load(3'b010, 32'h44, 32'hCAFEF00D, 1, 32'hCAFEF00D);

    // start pulsed again mid-access must be ignored
    exp_q.push_back(32'h0BADC0DE);
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    start = 1'b1; addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
    access(0, 32'h0BADC0DE, 30'hC0, 1'b0, 32'h0, 4'b0000);
    repeat (2) begin
      @(negedge clk);
      check("no_second_done", {31'h0, done}, 32'd0);
      check("no_second_req", {31'h0, mem_req}, 32'd0);
    end

    // random legal loads
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = $urandom_range(0, 32'hFFFF);
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      rd = $urandom();
      do_load(f3, a, rd, $urandom_range(0, 3), ref_load(f3, a[1:0], rd));
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
